rr_quantum_arbiter: RTL and testbench
=====================================

// Module: rr_quantum_arbiter
// PURPOSE
//   N-way round-robin arbiter sharing one resource among NREQ requesters, with
//   a per-grant quantum: an owner keeps the grant for up to QUANTUM cycles
//   while contended, then the grant rotates. Requests are latched one cycle
//   before arbitration, the same way as in the two-way arbiter. This block
//   generalises that arbiter for multi-master access to a shared datapath.
// PARAMETERS
//   NREQ     4   number of requesters, >= 2
//   QUANTUM  4   max consecutive grant cycles under contention, >= 1
//   IDW      2   width of gnt_id, = clog2(NREQ)
//   CW       3   quantum counter width, = clog2(QUANTUM+1)
// PORTS
//   clock    in   1     single clock; all state updates on posedge
//   reset    in   1     synchronous, active-high
//   req      in   NREQ  raw request vector; bit i = requester i
//   gnt      out  NREQ  registered grant vector, one-hot or all-zero
//   gnt_id   out  IDW   index of current owner; 0 when idle
//   busy     out  1     1 iff some gnt bit is set
//   qcnt     out  CW    cycles the current owner has held the grant; 0 when idle
// BEHAVIOUR
// - Reset (reset=1 at an edge): req_q=0, gnt=0, gnt_id=0, busy=0, qcnt=0,
//   last=NREQ-1, so the next search starts at index 0. Reset wins over all
//   other events, including a grant in progress.
// - Input latch: req_q <= req on every edge. All decisions use the pre-edge
//   req_q. A req first sampled at edge k can produce a gnt at edge k+1 at
//   the earliest, so gnt is visible after 2 edges.
// - Search: nxt(s) is the first set bit of req_q scanning s, s+1, ... mod NREQ.
// - States: IDLE (busy=0) and OWN (busy=1, owner o=gnt_id).
// - IDLE, req_q==0: stay in IDLE.
// - IDLE, req_q!=0: grant o=nxt(last+1), qcnt=1, go to OWN.
// - OWN, req_q[o]==0 (release):
//   - If any other bit is set, grant nxt(o+1) in the same edge (no bubble),
//     qcnt=1.
//   - Otherwise go to IDLE: gnt=0, qcnt=0.
//   - In both cases last=o.
// - OWN, req_q[o]==1, qcnt<QUANTUM: hold the grant, qcnt+=1.
// - OWN, req_q[o]==1, qcnt==QUANTUM:
//   - If another bit is set, rotate to nxt(o+1), qcnt=1, last=o.
//   - Otherwise hold the grant; qcnt saturates at QUANTUM.
// - QUANTUM=1: the grant rotates every cycle under contention.
// - Invariants:
//   - $onehot0(gnt).
//   - gnt[i] implies req_q[i] was 1 at the previous edge.
//   - busy == |gnt.
// - Fairness: a requester holding req continuously receives gnt within
//   (NREQ-1)*QUANTUM+2 edges of its first sampled edge.
// - A requester that drops req for one cycle loses the grant and waits its
//   round-robin turn.
// TESTING (NREQ=4, QUANTUM=3)
//   1) req=0000 for 10 cycles -> gnt=0000, busy=0, qcnt=0 throughout.
//   2) req=0100 held, from idle after reset -> at edge 2: gnt=0100, gnt_id=2.
//      qcnt goes 1,2,3,3,... and the grant holds indefinitely.
//   3) req=1111 held -> owners 0,1,2,3,0 in order, 3 cycles each, with no
//      idle cycle between owners.
//   4) req0 granted, req=0001->0000 while req3 is pending -> next edge
//      gnt=1000, qcnt=1.
//   5) req=0011, owner 0 at qcnt=2, reset pulsed for 1 cycle -> gnt=0000.
//      After release, first grant goes to 0 (search starts at 0).
//   6) Random req for 10k cycles -> gnt is always one-hot0 and no request
//      waits more than 11 edges. Cross-check against a reference model.

Source files
------------

// File: rtl/rr_quantum_arbiter.sv
// rr_quantum_arbiter: round-robin arbiter over NREQ latched requests, where each
// owner may keep the grant for up to QUANTUM cycles while another requester waits.
module rr_quantum_arbiter #(
    parameter int NREQ    = 4,
    parameter int QUANTUM = 4,
    parameter int IDW     = 2,
    parameter int CW      = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic [CW-1:0]   qcnt
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t          state_q, state_d;
    logic [NREQ-1:0] req_q, req_d, others;
    logic [IDW-1:0]  owner_q, owner_d, last_q, last_d;
    logic [CW-1:0]   qcnt_q, qcnt_d;
    // first set bit of r scanning s, s+1, ... modulo NREQ
    function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] r, input int s);
        logic [IDW-1:0] p;
        logic [IDW-1:0] k;
        p = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IDW'((s + i) % NREQ);
            if (r[k]) p = k;
        end
        return p;
    endfunction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            qcnt_q  <= qcnt_d;
        end
    end
    assign others = req_q & ~(NREQ'(1) << owner_q);
    always_comb begin
        req_d   = req;
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        qcnt_d  = qcnt_q;
        if (state_q == IDLE) begin
            if (|req_q) begin
                state_d = OWN;
                owner_d = pick(req_q, int'(last_q) + 1);
                qcnt_d  = CW'(1);
            end
        end else if (!req_q[owner_q] || (qcnt_q == CW'(QUANTUM) && |others)) begin
            // release or expired quantum: hand over without a bubble when possible
            last_d  = owner_q;
            state_d = |others ? OWN : IDLE;
            owner_d = |others ? pick(req_q, int'(owner_q) + 1) : owner_q;
            qcnt_d  = |others ? CW'(1) : '0;
        end else if (qcnt_q != CW'(QUANTUM)) begin
            qcnt_d = qcnt_q + CW'(1);
        end
    end
    always_comb begin
        busy   = state_q == OWN;
        gnt    = busy ? NREQ'(1) << owner_q : '0;
        gnt_id = busy ? owner_q : '0;
        qcnt   = qcnt_q;
    end
endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// tb_rr_quantum_arbiter: directed and random checks of rr_quantum_arbiter
// against an integer-level round-robin reference model.
module tb_rr_quantum_arbiter;
    localparam int N = 4, Q = 3, FAIR = (N - 1) * Q + 2;
    logic clock = 0, reset = 1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [1:0] gnt_id;
    logic busy;
    logic [1:0] qcnt;
    int tests = 0, fails = 0;
    int m_own = -1, m_cnt = 0, m_last = N - 1;
    logic [N-1:0] m_rq = '0;
    int age[N];
    bit waiting[N];

    rr_quantum_arbiter #(.NREQ(N), .QUANTUM(Q), .IDW(2), .CW(2)) dut (
        .clock(clock), .reset(reset), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .qcnt(qcnt)
    );

    always #5 clock = ~clock;

    function automatic bit has(logic [N-1:0] r, int i);
        return ((r >> i) & 1) != 0;
    endfunction

    function automatic int search(logic [N-1:0] r, int s);
        for (int i = 0; i < N; i++) if (has(r, (s + i) % N)) return (s + i) % N;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: one edge of the arbiter, using the request vector latched at the previous edge
    task automatic model_edge();
        bit oth;
        if (reset) begin
            m_rq = '0; m_own = -1; m_cnt = 0; m_last = N - 1;
            for (int i = 0; i < N; i++) begin waiting[i] = 0; age[i] = 0; end
            return;
        end
        if (m_own < 0) begin
            if (m_rq != 0) begin m_own = search(m_rq, m_last + 1); m_cnt = 1; end
        end else begin
            oth = search(m_rq & ~(N'(1) << m_own), 0) >= 0;
            if (!has(m_rq, m_own) || (m_cnt == Q && oth)) begin
                m_last = m_own;
                if (oth) begin m_own = search(m_rq, m_own + 1); m_cnt = 1; end
                else begin m_own = -1; m_cnt = 0; end
            end else if (m_cnt < Q) m_cnt++;
        end
        m_rq = req;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk("gnt", gnt, m_own < 0 ? 0 : 1 << m_own);
        chk("gnt_id", gnt_id, m_own < 0 ? 0 : m_own);
        chk("busy", busy, m_own >= 0);
        chk("qcnt", qcnt, m_cnt);
        chk("onehot0", $onehot0(gnt), 1);
        for (int i = 0; i < N; i++) begin
            if (has(m_rq, i) && !gnt[i]) begin
                age[i] = waiting[i] ? age[i] + 1 : 0;
                waiting[i] = 1;
                chk($sformatf("fair%0d", i), age[i] <= FAIR - 1, 1);
            end else waiting[i] = 0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        tick();
        chk("rst_gnt", gnt, 0); chk("rst_id", gnt_id, 0);
        chk("rst_busy", busy, 0); chk("rst_qcnt", qcnt, 0);
        reset = 0;
        // idle: no requests
        repeat (10) begin tick(); chk("t1_gnt", gnt, 0); chk("t1_busy", busy, 0); chk("t1_q", qcnt, 0); end
        // single requester holds indefinitely with saturating qcnt
        pulse_reset(); req = 4'b0100;
        tick(); chk("t2_e1", gnt, 0);
        tick(); chk("t2_gnt", gnt, 4'b0100); chk("t2_id", gnt_id, 2); chk("t2_q1", qcnt, 1);
        foreach (age[k]) begin tick(); chk("t2_q", qcnt, k < 1 ? 2 : 3); chk("t2_hold", gnt, 4'b0100); end
        // full contention rotates every QUANTUM edges without a bubble
        pulse_reset(); req = 4'b1111; tick();
        for (int e = 0; e < 13; e++) begin
            tick(); chk("t3_id", gnt_id, (e / Q) % N); chk("t3_busy", busy, 1); chk("t3_q", qcnt, e % Q + 1);
        end
        // owner releases while requester 3 waits
        pulse_reset(); req = 4'b0001; tick(); tick(); chk("t4_own", gnt, 4'b0001);
        req = 4'b1001; tick();
        req = 4'b1000; tick(); chk("t4_hold", gnt, 4'b0001);
        tick(); chk("t4_gnt", gnt, 4'b1000); chk("t4_q", qcnt, 1);
        // reset during a grant
        pulse_reset(); req = 4'b0011; tick(); tick(); tick(); chk("t5_q2", qcnt, 2);
        reset = 1; tick(); chk("t5_gnt", gnt, 0); chk("t5_q", qcnt, 0);
        reset = 0; tick(); chk("t5_e1", gnt, 0);
        tick(); chk("t5_first", gnt, 4'b0001); chk("t5_id", gnt_id, 0);
        // random requests with persistence so fairness gets exercised
        pulse_reset();
        repeat (10000) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
